// File: rtl/one_cold_encoder.sv
// Two-stage valid/ready pipeline that encodes an active-low one-cold vector into an index,
// flagging vectors that are not exactly one-cold and counting them (saturating at 255).
module one_cold_encoder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_err,
   output logic [7:0]       err_count
);

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_data_q;
   logic             s2_valid_q;
   logic [IDX_W-1:0] s2_idx_q;
   logic             s2_err_q;
   logic [7:0]       err_count_q;
   logic [7:0]       err_count_d;

   logic             s2_adv;
   logic             in_xfer;
   logic [WIDTH-1:0] zeros;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_any;
   logic             enc_err;

   assign s2_adv   = ~s2_valid_q | out_ready;
   // rst gates in_ready so nothing is accepted while the pipeline is held empty.
   assign in_ready = ~rst & (~s1_valid_q | s2_adv);
   assign in_xfer  = in_valid & in_ready;

   // Lowest-zero priority encoder; scanning high-to-low lets the lowest hit win.
   always_comb begin
      zeros   = ~s1_data_q;
      enc_idx = '0;
      enc_any = 1'b0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (zeros[i]) begin
            enc_idx = IDX_W'(i);
            enc_any = 1'b1;
         end
      end
      enc_err = ~enc_any | (|(zeros & (zeros - WIDTH'(1))));
   end

   always_comb begin
      err_count_d = err_count_q;
      if (s2_adv && s1_valid_q && enc_err && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '1;
      end else if (in_xfer) begin
         s1_valid_q <= 1'b1;
         s1_data_q  <= in_data;
      end else if (s2_adv) begin
         s1_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_idx_q   <= '0;
         s2_err_q   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_idx_q <= enc_idx;
            s2_err_q <= enc_err;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_q <= 8'd0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_idx   = s2_idx_q;
   assign out_err   = s2_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_one_cold_encoder.sv
// Bench for one_cold_encoder: directed vector table, backpressure, saturation, mid-stream reset
// and random stress against a queue-based reference model.
module tb_one_cold_encoder;
   localparam int WIDTH = 8;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '1;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [IDX_W-1:0] out_idx;
   logic             out_err;
   logic [7:0]       err_count;

   one_cold_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_err   (out_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             err;
   } res_t;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic [IDX_W-1:0] idx;
      logic             err;
   } vec_t;

   int   total = 0;
   int   bad = 0;
   int   exp_errs = 0;
   int   npush = 0;
   int   npop = 0;
   res_t sb[$];
   logic prev_stall = 1'b0;
   res_t prev_out;
   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [WIDTH-1:0] d);
      res_t r;
      int   cnt = 0;
      r.idx = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (!d[k]) begin
            if (cnt == 0) r.idx = IDX_W'(k);
            cnt++;
         end
      end
      r.err = (cnt != 1);
      return r;
   endfunction

   // Called at the falling edge: checks output transfers and records input transfers.
   task automatic monitor();
      if (prev_stall) begin
         check("hold_valid", out_valid, 1);
         check("hold_idx", out_idx, prev_out.idx);
         check("hold_err", out_err, prev_out.err);
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", out_valid, 0);
         end else begin
            res_t e = sb.pop_front();
            check("out_idx", out_idx, e.idx);
            check("out_err", out_err, e.err);
            npop++;
         end
      end
      if (in_valid && in_ready) begin
         res_t m = model(in_data);
         sb.push_back(m);
         if (m.err && exp_errs < 255) exp_errs++;
         npush++;
      end
      prev_stall   = out_valid && !out_ready;
      prev_out.idx = out_idx;
      prev_out.err = out_err;
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic send_check(input string tag, input logic [WIDTH-1:0] d,
                             input logic [IDX_W-1:0] ei, input logic ee, input logic [7:0] ec);
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_early"}, out_valid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_idx"}, out_idx, ei);
      check({tag, "_err"}, out_err, ee);
      check({tag, "_errcnt"}, err_count, ec);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ec;
      tbl[0]  = '{8'b1111_1110, 3'd0, 1'b0};
      tbl[1]  = '{8'b0111_1111, 3'd7, 1'b0};
      tbl[2]  = '{8'hFF,        3'd0, 1'b1};
      tbl[3]  = '{8'b1110_1101, 3'd1, 1'b1};
      tbl[4]  = '{8'b1011_1111, 3'd6, 1'b0};
      tbl[5]  = '{8'b1111_0111, 3'd3, 1'b0};
      tbl[6]  = '{8'h00,        3'd0, 1'b1};
      tbl[7]  = '{8'b1101_1111, 3'd5, 1'b0};
      tbl[8]  = '{8'b0111_1110, 3'd0, 1'b1};
      tbl[9]  = '{8'b1111_1011, 3'd2, 1'b0};
      tbl[10] = '{8'b1110_1111, 3'd4, 1'b0};
      tbl[11] = '{8'b1111_1101, 3'd1, 1'b0};

      // Asynchronous reset, observed before any clock edge.
      #1 rst = 1'b1;
      #2;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_err", out_err, 0);
      check("rst_err_count", err_count, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors; the first is offered right after reset release.
      ec = 8'd0;
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].err) ec++;
         send_check($sformatf("vec%0d", i), tbl[i].d, tbl[i].idx, tbl[i].err, ec);
      end
      exp_errs = int'(ec);

      // Backpressure: stall output for 5 cycles while streaming codes 0..7.
      prev_stall = 1'b0;
      npush = 0;
      npop = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = ~(8'd1 << npush);
         @(negedge clk);
         if (c >= 2) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_idx", out_idx, 0);
         end
         monitor();
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 40 && npop < 8; c++) begin
         in_valid = (npush < 8);
         in_data  = ~(8'd1 << npush);
         cycle();
      end
      in_valid = 1'b0;
      check("bp_delivered", npop, 8);
      check("bp_errcnt", err_count, ec);

      // Saturation: 300 malformed vectors back to back.
      npush = 0;
      for (int c = 0; c < 400 && npush < 300; c++) begin
         in_valid = 1'b1;
         in_data  = 8'hFF;
         cycle();
      end
      in_valid = 1'b0;
      repeat (4) cycle();
      check("sat_pushes", npush, 300);
      check("sat_count", err_count, 255);
      in_valid = 1'b1;
      repeat (3) cycle();
      in_valid = 1'b0;
      repeat (4) cycle();
      check("sat_hold", err_count, 255);
      check("sat_model", err_count, exp_errs);

      // Reset with both stages full.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hFE;
      repeat (2) cycle();
      rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_errcnt", err_count, 0);
      check("mid_rst_in_ready", in_ready, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      exp_errs = 0;
      prev_stall = 1'b0;
      send_check("post_rst", 8'b1011_1111, 3'd6, 1'b0, 8'd0);
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
      @(posedge clk);
      #1;

      // Random stress against the reference queue.
      npush = 0;
      npop = 0;
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) in_data = ~(8'd1 << $urandom_range(0, 7));
         else in_data = 8'($urandom);
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) cycle();
      check("stress_drain", sb.size(), 0);
      check("stress_count", npop, npush);
      check("stress_errcnt", err_count, exp_errs);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
